// File: rtl/mips32_pkg.sv
// Shared opcode constants, instruction classes and control-FSM states
// for the five-stage MIPS32 subset pipeline.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, BUBBLE} itype_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  // Unknown opcodes fall into HALT so a stray word stops the machine.
  function automatic itype_e decode_type(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      default:                                       return HALT;
    endcase
  endfunction

endpackage

// File: rtl/mips32_regfile.sv
// 32-entry register file: two write-before-read ports for ID, one write
// port from WB, plus a plain debug read port. R0 is hardwired to zero.
module mips32_regfile
  import mips32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  output logic [XLEN-1:0] dbg_rdata
);

  logic [XLEN-1:0] regs [32];

  // Writes to R0 are dropped; the array entry for R0 is never read out.
  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) regs[waddr] <= wdata;
  end

  // Same-cycle WB data is bypassed so ID never needs to wait on WB.
  assign rdata_a   = (raddr_a == 5'd0) ? '0 :
                     (we && waddr == raddr_a) ? wdata : regs[raddr_a];
  assign rdata_b   = (raddr_b == 5'd0) ? '0 :
                     (we && waddr == raddr_b) ? wdata : regs[raddr_b];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/mips32_pipe_fwd.sv
// Five-stage in-order MIPS32 subset core with IF/ID/EX/MEM/WB registers,
// optional EX operand forwarding (otherwise interlocks), EX-resolved
// branches with a two-bubble flush, and an IDLE/RUN/HALTED control FSM.
module mips32_pipe_fwd
  import mips32_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10,
  parameter int FWD_EN  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ld_en,
  input  logic                ld_sel,
  input  logic [((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW)-1:0] ld_addr,
  input  logic [XLEN-1:0]     ld_data,
  input  logic [4:0]          dbg_raddr,
  output logic [XLEN-1:0]     dbg_rdata,
  output logic                busy,
  output logic                halted,
  output logic [31:0]         retired
);

  state_e state_q, state_d;
  logic   running;
  logic [IMEM_AW-1:0] pc;
  logic   halt_seen;

  logic [XLEN-1:0] imem [2**IMEM_AW];
  logic [XLEN-1:0] dmem [2**DMEM_AW];
  logic [31:0]     ir;

  // IF/ID
  logic d_vld; logic [31:0] d_ir; logic [IMEM_AW-1:0] d_npc;
  // ID/EX
  itype_e e_ty; logic [5:0] e_op; logic [XLEN-1:0] e_a, e_b, e_imm;
  logic [IMEM_AW-1:0] e_npc; logic [4:0] e_rs, e_rt, e_dst; logic e_wr;
  // EX/MEM
  itype_e m_ty; logic [XLEN-1:0] m_alu, m_sd; logic [4:0] m_dst; logic m_wr;
  // MEM/WB
  itype_e w_ty; logic [XLEN-1:0] w_alu, w_lmd; logic [4:0] w_dst; logic w_wr;

  // ID decode
  logic [5:0] d_op; itype_e d_ty; logic [4:0] d_rs, d_rt, d_dst;
  logic d_wr, use_rs, use_rt, hit_e, hit_m, hit_w, stall;
  logic [XLEN-1:0] d_imm, rf_a, rf_b;
  // EX / WB datapath
  logic [XLEN-1:0] op_a, op_b, alu_b, alu, w_res, lmd;
  logic taken; logic [IMEM_AW-1:0] target;

  assign running = (state_q == S_RUN);
  assign busy    = running;
  assign halted  = (state_q == S_HALTED);
  assign ir      = imem[pc][31:0];

  assign d_op   = d_ir[31:26];
  assign d_ty   = d_vld ? decode_type(d_op) : BUBBLE;
  assign d_rs   = d_ir[25:21];
  assign d_rt   = d_ir[20:16];
  assign d_dst  = (d_ty == RR_ALU) ? d_ir[15:11] : d_ir[20:16];
  assign d_wr   = (d_ty == RR_ALU || d_ty == RM_ALU || d_ty == LOAD) && d_dst != 5'd0;
  assign d_imm  = {{(XLEN-16){d_ir[15]}}, d_ir[15:0]};
  assign use_rs = (d_ty == RR_ALU || d_ty == RM_ALU || d_ty == LOAD ||
                   d_ty == STORE || d_ty == BRANCH);
  assign use_rt = (d_ty == RR_ALU || d_ty == STORE);

  // A register hazard exists when an older writer targets a register ID reads.
  assign hit_e = e_wr && ((use_rs && e_dst == d_rs) || (use_rt && e_dst == d_rt));
  assign hit_m = m_wr && ((use_rs && m_dst == d_rs) || (use_rt && m_dst == d_rt));
  assign hit_w = w_wr && ((use_rs && w_dst == d_rs) || (use_rt && w_dst == d_rt));
  assign stall = (FWD_EN != 0) ? (hit_e && e_ty == LOAD) : (hit_e || hit_m || hit_w);

  assign w_res = (w_ty == LOAD) ? w_lmd : w_alu;
  assign lmd   = dmem[m_alu[DMEM_AW-1:0]];

  mips32_regfile #(.XLEN(XLEN)) u_rf (
    .clk(clk), .we(running && w_wr), .waddr(w_dst), .wdata(w_res),
    .raddr_a(d_rs), .raddr_b(d_rt), .dbg_raddr(dbg_raddr),
    .rdata_a(rf_a), .rdata_b(rf_b), .dbg_rdata(dbg_rdata)
  );

  // EX operand select: newest producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    op_a = e_a;
    op_b = e_b;
    if (FWD_EN != 0) begin
      if (m_wr && m_dst == e_rs)      op_a = m_alu;
      else if (w_wr && w_dst == e_rs) op_a = w_res;
      if (m_wr && m_dst == e_rt)      op_b = m_alu;
      else if (w_wr && w_dst == e_rt) op_b = w_res;
    end
  end

  // ALU plus branch resolution; loads/stores use the default add for address.
  always_comb begin
    alu_b = (e_ty == RR_ALU) ? op_b : e_imm;
    case (e_op)
      OP_SUB, OP_SUBI: alu = op_a - alu_b;
      OP_AND:          alu = op_a & alu_b;
      OP_OR:           alu = op_a | alu_b;
      OP_SLT, OP_SLTI: alu = {{(XLEN-1){1'b0}}, op_a < alu_b};
      OP_MUL:          alu = op_a * alu_b;
      default:         alu = op_a + alu_b;
    endcase
    taken  = (e_ty == BRANCH) && ((e_op == OP_BEQZ) == (op_a == '0));
    target = e_npc + e_imm[IMEM_AW-1:0];
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start launches from IDLE/HALTED, a retiring HALT stops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start) state_d = S_RUN;
      S_RUN:            if (w_ty == HALT) state_d = S_HALTED;
      default:          state_d = S_IDLE;
    endcase
  end

  // Instruction memory load port; locked while the core runs.
  always_ff @(posedge clk) begin
    if (ld_en && !ld_sel && !running) imem[ld_addr[IMEM_AW-1:0]] <= ld_data;
  end

  // Data memory: loader when idle, MEM-stage stores when running. State is
  // forced to IDLE asynchronously, so no store lands once reset asserts.
  always_ff @(posedge clk) begin
    if (ld_en && ld_sel && !running)  dmem[ld_addr[DMEM_AW-1:0]] <= ld_data;
    else if (running && m_ty == STORE) dmem[m_alu[DMEM_AW-1:0]] <= m_sd;
  end

  // Pipeline advance; flush beats stall, and HALT in ID closes the fetch gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || (start && !running)) begin
      pc <= '0; halt_seen <= 1'b0; retired <= '0;
      d_vld <= 1'b0; d_ir <= '0; d_npc <= '0;
      e_ty <= BUBBLE; e_op <= '0; e_a <= '0; e_b <= '0; e_imm <= '0;
      e_npc <= '0; e_rs <= '0; e_rt <= '0; e_dst <= '0; e_wr <= 1'b0;
      m_ty <= BUBBLE; m_alu <= '0; m_sd <= '0; m_dst <= '0; m_wr <= 1'b0;
      w_ty <= BUBBLE; w_alu <= '0; w_lmd <= '0; w_dst <= '0; w_wr <= 1'b0;
    end else if (running) begin
      if (w_ty != BUBBLE && retired != '1) retired <= retired + 32'd1;
      w_ty <= m_ty; w_alu <= m_alu; w_lmd <= lmd; w_dst <= m_dst; w_wr <= m_wr;
      m_ty <= e_ty; m_alu <= alu; m_sd <= op_b; m_dst <= e_dst; m_wr <= e_wr;
      if (taken) begin
        e_ty <= BUBBLE; e_wr <= 1'b0; d_vld <= 1'b0; pc <= target;
      end else if (stall) begin
        e_ty <= BUBBLE; e_wr <= 1'b0;
      end else begin
        e_ty <= d_ty; e_op <= d_op; e_a <= rf_a; e_b <= rf_b; e_imm <= d_imm;
        e_npc <= d_npc; e_rs <= d_rs; e_rt <= d_rt; e_dst <= d_dst; e_wr <= d_wr;
        if (halt_seen || d_ty == HALT) begin
          d_vld <= 1'b0;
          halt_seen <= 1'b1;
        end else begin
          d_vld <= 1'b1; d_ir <= ir; d_npc <= pc + IMEM_AW'(1); pc <= pc + IMEM_AW'(1);
        end
      end
    end
  end

endmodule

// File: doc/mips32_pipe_fwd.md
MIPS32_PIPE_FWD -- requirements
Module: mips32_pipe_fwd

Interface
REQ-001 Parameter XLEN, 32, datapath and register width.
REQ-002 Parameter IMEM_AW, 10, instruction memory address bits (depth 2^IMEM_AW words).
REQ-003 Parameter DMEM_AW, 10, data memory address bits (depth 2^DMEM_AW words).
REQ-004 Parameter FWD_EN, 1, 1 enables operand forwarding; 0 replaces it with interlock stalls.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; starts execution from PC 0.
REQ-008 ld_en  in  1  program/data load strobe.
REQ-009 ld_sel  in  1  0 = instruction memory, 1 = data memory.
REQ-010 ld_addr  in  max(IMEM_AW,DMEM_AW)  load word address; upper bits unused by the narrower memory.
REQ-011 ld_data  in  32/XLEN  load word.
REQ-012 dbg_raddr  in  5  register-file debug read address.
REQ-013 dbg_rdata  out  XLEN  combinational read of Reg[dbg_raddr]; R0 reads 0.
REQ-014 busy  out  1  high in RUN state.
REQ-015 halted  out  1  high in HALTED state.
REQ-016 retired  out  32  count of retired non-bubble instructions, saturating at all-ones.

Function
REQ-017 Control FSM states: IDLE, RUN, HALTED; start in IDLE or HALTED -> RUN, clears all pipeline registers to bubbles, sets PC=0 and retired=0; start in RUN is ignored.
REQ-018 ld_en writes the selected memory at ld_addr only when not in RUN; ignored in RUN.
REQ-019 Five stages IF, ID, EX, MEM, WB, one clock each; a non-stalled instruction retires 4 cycles after fetch.
REQ-020 Opcodes [31:26]: ADD 00, SUB 01, AND 02, OR 03, SLT 04, MUL 05, LW 08, SW 09, ADDI 0A, SUBI 0B, SLTI 0C, BNEQZ 0D, BEQZ 0E, HLT 3F; any other opcode behaves as HLT.
REQ-021 Fields: rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended to XLEN; RR ops write rd, RM ops and LW write rt.
REQ-022 SLT/SLTI compare unsigned, result 0 or 1; MUL keeps low XLEN bits; all arithmetic wraps modulo 2^XLEN.
REQ-023 Memory addresses taken modulo depth (low IMEM_AW/DMEM_AW bits); PC wraps from 2^IMEM_AW-1 to 0.
REQ-024 R0 reads 0 always; writes to R0 discarded, never forwarded.
REQ-025 Register file is write-before-read: a WB write is visible to ID in the same cycle.
REQ-026 FWD_EN=1: EX operands forwarded from EX/MEM (ALU result) with priority over MEM/WB (ALU result or load data).
REQ-027 FWD_EN=1: LW followed immediately by a consumer of its rt stalls IF/ID one cycle, inserting one bubble in EX.
REQ-028 FWD_EN=0: ID stalls while any older in-flight instruction in EX, MEM or WB writes a register it reads.
REQ-029 Branch target = NPC + imm; resolved in EX; BEQZ taken if rs==0, BNEQZ taken if rs!=0.
REQ-030 Taken branch: the two younger instructions (IF/ID, ID/EX) become bubbles; next fetch at target; penalty 2 cycles.
REQ-031 A bubble never writes registers or memory and is not counted in retired.
REQ-032 HLT decoded in ID stops fetch; a HLT in ID that a branch in EX squashes has no effect.
REQ-033 On HLT retiring in WB: all older instructions have retired, FSM -> HALTED, pipeline frozen.
REQ-034 Stall and taken-branch flush in the same cycle: flush wins.

Reset
REQ-035 rst_n low: FSM=IDLE, PC=0, all pipeline registers bubbles, busy=0, halted=0, retired=0; register file and memories not cleared.
REQ-036 Reset asserted mid-RUN aborts instantly; no partial store completes after assertion.

Structure
REQ-037 Package mips32_pkg holds opcode constants, instruction-type enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, BUBBLE) and FSM state enum.
REQ-038 Sub-module mips32_regfile: 32xXLEN, two read ports, one write port, debug read port, R0 hardwired zero.

Verification
REQ-039 Load ADDI R1,R0,5; ADD R2,R1,R1; HLT; start -> R2=10, halted set, retired=3, no stall with FWD_EN=1.
REQ-040 LW R3,0(R0) with DMEM[0]=7; ADD R4,R3,R3; HLT -> R4=14; exactly one bubble cycle; FWD_EN=0 run gives same R4, more cycles.
REQ-041 ADDI R1,R0,0; BEQZ R1,+2; ADDI R5,R0,9; ADDI R6,R0,9; ADDI R7,R0,3; HLT -> R5=R6=0, R7=3, retired=4.
REQ-042 SW R1,4(R0) directly after a taken BNEQZ -> DMEM[4] unchanged.
REQ-043 ADDI R0,R0,1; ADD R8,R0,R0; HLT -> R8=0; opcode 0x10 program halts like HLT.
REQ-044 Assert rst_n low mid-run, release, start -> busy, retired restart from 0 and program reruns to identical results.
